// File: rtl/instr_mem_loader_pkg.sv
// Shared types for the instruction-memory loader.
// State encoding and bus widths used by loader, packer and bench.
package instr_load_pkg;

    localparam int WORD_W = 32;
    localparam int BYTE_W = 8;
    localparam int LEN_W  = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_DONE
    } state_t;

endpackage

// File: rtl/instr_mem_loader_if.sv
// Byte-stream valid/ready channel feeding the loader.
// master drives bytes, slave returns in_ready.
interface instr_mem_loader_if;
    import instr_load_pkg::*;

    logic [BYTE_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/instr_mem_loader_packer.sv
// Big-endian byte-to-word assembler: 3-byte shift reg plus 2-bit count.
// The finished word and its valid strobe appear the cycle after byte 4.
module byte_to_word_packer
    import instr_load_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,
    input  logic              i_byte_en,
    input  logic [BYTE_W-1:0] i_byte,
    output logic              o_last_byte,
    output logic              o_word_valid,
    output logic [WORD_W-1:0] o_word
);

    logic [1:0]               r_cnt;
    logic [WORD_W-BYTE_W-1:0] r_shift;
    logic [WORD_W-1:0]        r_word;
    logic                     r_valid;

    assign o_last_byte  = (r_cnt == 2'd3);
    assign o_word_valid = r_valid;
    assign o_word       = r_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_shift <= '0;
            r_word  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (i_clear) begin
                r_cnt   <= '0;
                r_shift <= '0;
            end else if (i_byte_en) begin
                r_cnt <= r_cnt + 2'd1;
                if (r_cnt == 2'd3) begin
                    r_word  <= {r_shift, i_byte};
                    r_valid <= 1'b1;
                end else begin
                    r_shift <= {r_shift[WORD_W-2*BYTE_W-1:0], i_byte};
                end
            end
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Streams a length-prefixed program into instruction memory from BASE_WORD,
// holding the CPU in reset for the duration of the load.
module instr_mem_loader
    import instr_load_pkg::*;
#(
    parameter int DEPTH     = 128,
    parameter int ADDR_W    = 7,
    parameter int BASE_WORD = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    instr_mem_loader_if.slave s_in,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam logic [LEN_W-1:0]  MAX_LEN = LEN_W'(DEPTH - BASE_WORD);
    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_WORD);
    localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);

    state_t             r_state;
    state_t             w_next;
    logic [BYTE_W-1:0]  r_len_hi;
    logic [ADDR_W-1:0]  r_nwords;
    logic [ADDR_W-1:0]  r_wcnt;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic               r_err;
    logic               r_done;

    logic [LEN_W-1:0]   w_len;
    logic               w_ovf;
    logic               w_zero;
    logic               w_accept;
    logic               w_start_ok;
    logic               w_byte_en;
    logic               w_last_byte;
    logic               w_word_end;
    logic               w_last_word;
    logic               w_word_valid;
    logic [WORD_W-1:0]  w_word;

    assign w_len       = {r_len_hi, s_in.in_data};
    assign w_ovf       = (w_len > MAX_LEN);
    assign w_zero      = (w_len == '0);
    assign w_accept    = s_in.in_valid & s_in.in_ready;
    assign w_start_ok  = start && (r_state == S_IDLE);
    assign w_byte_en   = w_accept && (r_state == S_DATA);
    assign w_word_end  = w_byte_en & w_last_byte;
    // Length is range-checked before DATA, so the low bits hold N exactly.
    assign w_last_word = (r_wcnt == (r_nwords - ONE));

    byte_to_word_packer u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clear      (w_start_ok),
        .i_byte_en    (w_byte_en),
        .i_byte       (s_in.in_data),
        .o_last_byte  (w_last_byte),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        s_in.in_ready = 1'b0;
        cpu_hold      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) w_next = S_LEN_HI;
            end
            S_LEN_HI: begin
                s_in.in_ready = 1'b1;
                cpu_hold      = 1'b1;
                if (s_in.in_valid) w_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                s_in.in_ready = 1'b1;
                cpu_hold      = 1'b1;
                if (s_in.in_valid) begin
                    w_next = (w_zero || w_ovf) ? S_DONE : S_DATA;
                end
            end
            S_DATA: begin
                s_in.in_ready = 1'b1;
                cpu_hold      = 1'b1;
                if (w_word_end && w_last_word) w_next = S_DONE;
            end
            S_DONE: begin
                cpu_hold = 1'b1;
                w_next   = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len_hi  <= '0;
            r_nwords  <= '0;
            r_wcnt    <= '0;
            r_wr_addr <= '0;
            r_err     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= (r_state == S_DONE);
            if (w_start_ok) begin
                r_err  <= 1'b0;
                r_wcnt <= '0;
            end
            if (w_accept && (r_state == S_LEN_HI)) begin
                r_len_hi <= s_in.in_data;
            end
            if (w_accept && (r_state == S_LEN_LO)) begin
                r_nwords <= w_len[ADDR_W-1:0];
                if (w_ovf) r_err <= 1'b1;
            end
            if (w_word_end) begin
                r_wr_addr <= BASE + r_wcnt;
                r_wcnt    <= r_wcnt + ONE;
            end
        end
    end

    assign wr_en   = w_word_valid;
    assign wr_data = w_word;
    assign wr_addr = r_wr_addr;
    assign done    = r_done;
    assign err     = r_err;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: driver queues expected writes,
// done latencies and err per load; a negedge monitor pops and compares.
module tb_instr_mem_loader;
    import instr_load_pkg::*;

    localparam int DEPTH     = 128;
    localparam int ADDR_W    = 7;
    localparam int BASE_WORD = 1;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              cpu_hold;
    logic              done;
    logic              err;

    instr_mem_loader_if bus ();

    instr_mem_loader #(
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .BASE_WORD (BASE_WORD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .s_in     (bus),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t         exp_wr[$];
    bit          exp_err_q[$];
    int          acc4_q[$];
    int          fin_q[$];
    int          done_cnt = 0;
    logic [31:0] wq[$];

    function automatic void check(string name, logic [63:0] act,
                                  logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endfunction

    // Monitor: every write and done pulse is matched to the model.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en) begin
                if (exp_wr.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    check("wr_addr", wr_addr, e.addr);
                    check("wr_data", wr_data, e.data);
                end
                if (acc4_q.size() == 0) check("wr_latency_ref", 0, 1);
                else check("wr_latency", cyc, acc4_q.pop_front() + 1);
            end
            if (done) begin
                if (exp_err_q.size() == 0) check("unexpected_done", 1, 0);
                else check("err_at_done", err, exp_err_q.pop_front());
                if (fin_q.size() == 0) check("done_latency_ref", 0, 1);
                else check("done_latency", cyc, fin_q.pop_front() + 2);
                check("writes_pending_at_done", exp_wr.size(), 0);
                check("hold_released", cpu_hold, 0);
                check("ready_at_done", bus.in_ready, 0);
                done_cnt++;
            end
        end
    end

    function automatic bit gap(input int mode);
        if (mode == 1) return 1'b1;
        if (mode == 2) return ($urandom_range(0, 2) == 0);
        return 1'b0;
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit g,
                             input bit w4, input bit fin, input bit pst);
        int budget;
        if (g) begin
            bus.in_valid = 1'b0;
            @(posedge clk); #1;
        end
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        start        = pst;
        budget       = 0;
        while (!bus.in_ready && budget < 20) begin
            @(posedge clk); #1;
            start = 1'b0;
            budget++;
        end
        if (!bus.in_ready) begin
            check("in_ready_timeout", 0, 1);
            bus.in_valid = 1'b0;
            return;
        end
        if (w4)  acc4_q.push_back(cyc);
        if (fin) fin_q.push_back(cyc);
        @(posedge clk); #1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    task automatic do_start(input bit with_valid);
        start = 1'b1;
        if (with_valid) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'hA5;
        end
        check("idle_ready", bus.in_ready, 0);
        check("idle_hold", cpu_hold, 0);
        @(posedge clk); #1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        check("hold_after_start", cpu_hold, 1);
        check("ready_len_hi", bus.in_ready, 1);
    endtask

    // Reference: N words land at BASE_WORD+k unless N exceeds free space.
    task automatic run_load(input int n, input int mode, input int start_at);
        bit          ovf;
        int          target, budget, idx;
        logic [15:0] n16;
        logic [31:0] w;
        wr_t         e;
        n16 = 16'(n);
        ovf = (n > DEPTH - BASE_WORD);
        exp_err_q.push_back(ovf);
        if (!ovf) begin
            for (int k = 0; k < n; k++) begin
                e.addr = ADDR_W'(BASE_WORD + k);
                e.data = wq[k];
                exp_wr.push_back(e);
            end
        end
        target = done_cnt + 1;
        do_start(mode == 0);
        send_byte(n16[15:8], gap(mode), 1'b0, 1'b0, 1'b0);
        send_byte(n16[7:0], gap(mode), 1'b0, (n == 0) || ovf, 1'b0);
        if (!ovf) begin
            for (int k = 0; k < n; k++) begin
                w = wq[k];
                for (int j = 0; j < 4; j++) begin
                    idx = 2 + 4 * k + j;
                    send_byte(w[31-8*j -: 8], gap(mode), j == 3,
                              (k == n - 1) && (j == 3), idx == start_at);
                end
            end
        end
        budget = 0;
        while (done_cnt < target && budget < 50) begin
            @(posedge clk); #1;
            budget++;
        end
        check("done_seen", done_cnt >= target, 1);
        @(posedge clk); #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_wr_en"}, wr_en, 0);
        check({tag, "_wr_addr"}, wr_addr, 0);
        check({tag, "_wr_data"}, wr_data, 0);
        check({tag, "_cpu_hold"}, cpu_hold, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_in_ready"}, bus.in_ready, 0);
    endtask

    task automatic fill_random(input int n);
        wq.delete();
        for (int k = 0; k < n; k++) wq.push_back($urandom);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          n;
        logic [31:0] w0, w1;
        wr_t         e;
        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        #3;
        check_outputs_zero("reset");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed: N=3 back-to-back, then with alternate-cycle gaps.
        wq.delete();
        wq.push_back(32'h2008000C);
        wq.push_back(32'h20090005);
        wq.push_back(32'h01095820);
        run_load(3, 0, -1);
        run_load(3, 1, -1);

        // Empty program.
        run_load(0, 0, -1);

        // Overflow: no writes, ready stays low, err sticky until next start.
        run_load(128, 0, -1);
        bus.in_data  = 8'h20;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("ovf_ready_low", bus.in_ready, 0);
            check("ovf_err_sticky", err, 1);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;

        // Reset after word 1 and half of word 2.
        w0 = 32'hDEADBEEF;
        w1 = 32'h12345678;
        e.addr = ADDR_W'(BASE_WORD);
        e.data = w0;
        exp_wr.push_back(e);
        do_start(1'b0);
        send_byte(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        send_byte(8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 4; j++)
            send_byte(w0[31-8*j -: 8], 1'b0, j == 3, 1'b0, 1'b0);
        send_byte(w1[31:24], 1'b0, 1'b0, 1'b0, 1'b0);
        send_byte(w1[23:16], 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        check("midreset_word1_written", exp_wr.size(), 0);
        exp_wr.delete();
        exp_err_q.delete();
        acc4_q.delete();
        fin_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        wq.delete();
        wq.push_back(32'hA5A55A5A);
        run_load(1, 0, -1);

        // start pulsed mid-payload must be ignored.
        wq.delete();
        wq.push_back(32'h11223344);
        wq.push_back(32'h55667788);
        wq.push_back(32'h99AABBCC);
        run_load(3, 0, 7);

        // Largest legal program: last word lands at DEPTH-1.
        fill_random(DEPTH - BASE_WORD);
        run_load(DEPTH - BASE_WORD, 0, -1);

        // Randomized loads, gaps, stray starts and overflows.
        for (int r = 0; r < 12; r++) begin
            case ($urandom_range(0, 5))
                0:       n = $urandom_range(DEPTH - BASE_WORD + 1, 65535);
                1:       n = 0;
                default: n = $urandom_range(1, 6);
            endcase
            fill_random((n > DEPTH - BASE_WORD) ? 0 : n);
            run_load(n, 2, (n > 0) ? $urandom_range(2, 4 * n + 1) : -1);
        end

        check("final_queue_empty", exp_wr.size() + exp_err_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
